// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 keyboard receiver that tracks a single held letter as a one-hot vector plus index.
// Optional PS2_PARITY_CHECK_EN: drop frames whose odd parity over D0..D7+P fails.
module ps2_letter_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PS2_CLK,
   input  logic        PS2_DAT,
   output logic [25:0] letter,
   output logic [4:0]  key_code,
   output logic        key_valid,
   output logic        frame_err
);
   // state    | meaning
   // S_IDLE   | waiting for make, F0 or E0
   // S_BRK    | F0 seen, next byte is a break code
   // S_EXT    | E0 seen, extended key in progress
   // S_EXTBRK | E0 F0 seen, next byte is an extended break
   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} scan_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   logic [2:0]    clk_sync_q, clk_sync_d;
   logic [1:0]    dat_sync_q, dat_sync_d;
   logic          rx_busy_q, rx_busy_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_stb_q, byte_stb_d;
   logic [7:0]    byte_q, byte_d;
   logic          frame_err_q, frame_err_d;
   scan_t         state_q, state_d;
   logic [25:0]   letter_q, letter_d;
   logic [4:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;

   logic          ps2_fall, dat_s, frame_ok;
   logic          code_hit, held_match;
   logic [4:0]    code_idx;

   assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign dat_s    = dat_sync_q[1];
   assign clk_sync_d = {clk_sync_q[1:0], PS2_CLK};
   assign dat_sync_d = {dat_sync_q[0], PS2_DAT};

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat_s & (^shift_q);
`else
   assign frame_ok = dat_s;
`endif

   // shift_q collects D0..D7 then parity; the 11th sample is the stop bit itself
   always_comb begin
      rx_busy_d   = rx_busy_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tmo_d       = tmo_q;
      byte_stb_d  = 1'b0;
      byte_d      = byte_q;
      frame_err_d = 1'b0;
      if (ps2_fall) begin
         tmo_d = '0;
         if (!rx_busy_q) begin
            if (!dat_s) begin
               rx_busy_d = 1'b1;
               bit_cnt_d = 4'd1;
            end
         end else if (bit_cnt_q == 4'd10) begin
            rx_busy_d = 1'b0;
            bit_cnt_d = 4'd0;
            if (frame_ok) begin
               byte_stb_d = 1'b1;
               byte_d     = shift_q[7:0];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            shift_d   = {dat_s, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (rx_busy_q) begin
         if (tmo_q == TMO_MAX) begin
            rx_busy_d   = 1'b0;
            bit_cnt_d   = 4'd0;
            frame_err_d = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_comb begin
      code_hit = 1'b1;
      code_idx = 5'd0;
      case (byte_q)
         8'h1C: code_idx = 5'd0;
         8'h32: code_idx = 5'd1;
         8'h21: code_idx = 5'd2;
         8'h23: code_idx = 5'd3;
         8'h24: code_idx = 5'd4;
         8'h2B: code_idx = 5'd5;
         8'h34: code_idx = 5'd6;
         8'h33: code_idx = 5'd7;
         8'h43: code_idx = 5'd8;
         8'h3B: code_idx = 5'd9;
         8'h42: code_idx = 5'd10;
         8'h4B: code_idx = 5'd11;
         8'h3A: code_idx = 5'd12;
         8'h31: code_idx = 5'd13;
         8'h44: code_idx = 5'd14;
         8'h4D: code_idx = 5'd15;
         8'h15: code_idx = 5'd16;
         8'h2D: code_idx = 5'd17;
         8'h1B: code_idx = 5'd18;
         8'h2C: code_idx = 5'd19;
         8'h3C: code_idx = 5'd20;
         8'h2A: code_idx = 5'd21;
         8'h1D: code_idx = 5'd22;
         8'h22: code_idx = 5'd23;
         8'h35: code_idx = 5'd24;
         8'h1A: code_idx = 5'd25;
         default: code_hit = 1'b0;
      endcase
   end

   // key_code only changes together with a new letter, so it names the held key while letter != 0
   assign held_match = (letter_q != '0) && code_hit && (code_idx == key_code_q);

   always_comb begin
      state_d     = state_q;
      letter_d    = letter_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      if (byte_stb_q) begin
         case (state_q)
            S_IDLE: begin
               if (byte_q == 8'hF0) begin
                  state_d = S_BRK;
               end else if (byte_q == 8'hE0) begin
                  state_d = S_EXT;
               end else if (code_hit && !held_match) begin
                  letter_d    = 26'd1 << code_idx;
                  key_code_d  = code_idx;
                  key_valid_d = 1'b1;
               end
            end
            S_BRK: begin
               if (held_match) letter_d = '0;
               state_d = S_IDLE;
            end
            S_EXT:    state_d = (byte_q == 8'hF0) ? S_EXTBRK : S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync_q  <= 3'b111;
         dat_sync_q  <= 2'b11;
         rx_busy_q   <= 1'b0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= '0;
         tmo_q       <= '0;
         byte_stb_q  <= 1'b0;
         byte_q      <= '0;
         frame_err_q <= 1'b0;
         state_q     <= S_IDLE;
         letter_q    <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         dat_sync_q  <= dat_sync_d;
         rx_busy_q   <= rx_busy_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         byte_stb_q  <= byte_stb_d;
         byte_q      <= byte_d;
         frame_err_q <= frame_err_d;
         state_q     <= state_d;
         letter_q    <= letter_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign letter    = letter_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Randomised scoreboard bench for ps2_letter_decoder: a key-tracking model predicts pulses and held letter.
module tb_ps2_letter_decoder;
   localparam int TMO = 1000;

   logic        clk = 1'b0;
   logic        reset, PS2_CLK, PS2_DAT;
   logic [25:0] letter;
   logic [4:0]  key_code;
   logic        key_valid, frame_err;

   ps2_letter_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
      .letter(letter), .key_code(key_code), .key_valid(key_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int exp_q[$];
   int fe_exp = 0, fe_seen = 0;
   int held = -1;
   bit m_brk = 0, m_ext = 0, m_extbrk = 0;
   logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

   function automatic int lookup(logic [7:0] b);
      for (int i = 0; i < 26; i++) if (codes[i] == b) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_letter();
      return (held < 0) ? 32'd0 : (32'd1 << held);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // keyboard protocol model: one pending prefix at a time, single held key
   task automatic model_byte(logic [7:0] b);
      int idx;
      idx = lookup(b);
      if (m_extbrk) m_extbrk = 0;
      else if (m_ext) begin
         m_ext = 0;
         if (b == 8'hF0) m_extbrk = 1;
      end else if (m_brk) begin
         m_brk = 0;
         if (idx >= 0 && idx == held) held = -1;
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (idx >= 0 && idx != held) begin
         held = idx;
         exp_q.push_back(idx);
      end
   endtask

   task automatic ps2_bit(bit v);
      PS2_DAT = v;
      repeat (3) @(posedge clk);
      PS2_CLK = 1'b0;
      repeat (4) @(posedge clk);
      PS2_CLK = 1'b1;
      @(posedge clk);
   endtask

   task automatic send_frame(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0);
      bit ok;
      ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
      ok = ok && !bad_par;
`endif
      if (ok) model_byte(b);
      else fe_exp++;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~(^b) ^ bad_par);
      ps2_bit(~bad_stop);
      PS2_DAT = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check($sformatf("letter_after_%02h", b), 32'(letter), exp_letter());
      check("frame_err_count", fe_seen, fe_exp);
   endtask

   always @(negedge clk) begin : monitor
      int e;
      if (reset === 1'b1 && key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_key_valid: got code %0d expected no pulse at %0t", key_code, $time);
         end else begin
            e = exp_q.pop_front();
            check("key_code", 32'(key_code), 32'(e));
            check("letter_at_pulse", 32'(letter), 32'd1 << e);
         end
      end
      if (frame_err === 1'b1) fe_seen++;
   end

   initial begin
      int r;
      logic [7:0] b;
      reset = 1'b0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_letter", 32'(letter), 32'd0);
      check("reset_key_code", 32'(key_code), 32'd0);
      check("reset_key_valid", 32'(key_valid), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      reset = 1'b1;
      repeat (5) @(posedge clk);

      send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
      send_frame(8'h1B);
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1B);
      send_frame(8'hE0); send_frame(8'h1C);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'h1A);
      send_frame(8'hF0); send_frame(8'h1A);
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'h32, 1'b0, 1'b1);

      // partial frame abandoned mid-way must time out
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      PS2_DAT = 1'b1;
      fe_exp++;
      repeat (TMO + 200) @(posedge clk);
      #1;
      check("timeout_frame_err", fe_seen, fe_exp);
      send_frame(8'h24);
      check("key_code_E", 32'(key_code), 32'd4);

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         b = codes[$urandom_range(0, 25)];
         case (r)
            5: send_frame(8'hF0);
            6: send_frame(8'hE0);
            7: send_frame(8'($urandom_range(0, 255)));
            8: send_frame(b, 1'b0, 1'b1);
            9: send_frame(b, 1'b1, 1'b0);
            default: send_frame(b);
         endcase
      end

      send_frame(8'h24);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_reset_letter", 32'(letter), 32'd0);
      check("async_reset_key_code", 32'(key_code), 32'd0);
      held = -1; m_brk = 0; m_ext = 0; m_extbrk = 0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      send_frame(8'h24);
      check("post_reset_key_code", 32'(key_code), 32'd4);

      repeat (10) @(posedge clk);
      check("pending_pulses", 32'(exp_q.size()), 32'd0);
      check("final_frame_err_count", fe_seen, fe_exp);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
